sample_clk_div: RTL

SAMPLE_CLK_DIV -- requirements
Module: sample_clk_div

---
 rtl/sample_clk_div.sv | 96 +++++++++
 1 files changed

// File: rtl/sample_clk_div.sv
// Multi-channel sample-clock divider with shadowed divisor updates.
// A new divisor is applied only at a full-period boundary, in bypass, or on a sync strobe.
module sample_clk_div #(
  parameter int          NCH       = 2,
  parameter int          WIDTH     = 16,
  parameter int unsigned RESET_DIV = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [NCH*WIDTH-1:0] cfg_div,
  input  logic                 sync,
  output logic [NCH-1:0]       div_clk,
  output logic [NCH-1:0]       ce,
  output logic [NCH-1:0]       pending
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(RESET_DIV);

  logic accept;

  assign cfg_ready = !rst && (pending == '0);
  assign accept    = cfg_valid && cfg_ready;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0] act;
    logic [WIDTH-1:0] shd;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] fld;
    logic             lvl;
    logic             ce_r;
    logic             pend;

    assign fld = cfg_div[i*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        act  <= RST_DIV;
        shd  <= RST_DIV;
        cnt  <= '0;
        lvl  <= 1'b1;
        ce_r <= 1'b0;
        pend <= 1'b0;
      end else begin
        if (sync) begin
          // Realign: every channel restarts its high phase this cycle.
          if (pend) begin
            act  <= shd;
            pend <= 1'b0;
          end
          cnt  <= '0;
          lvl  <= 1'b1;
          ce_r <= 1'b1;
        end else if (act == '0) begin
          if (pend) begin
            act  <= shd;
            pend <= 1'b0;
          end
          cnt  <= '0;
          lvl  <= 1'b1;
          ce_r <= 1'b1;
        end else if (cnt == act - ONE) begin
          cnt <= '0;
          if (!lvl) begin
            // Rising edge is the only point where a new divisor may take over.
            lvl  <= 1'b1;
            ce_r <= 1'b1;
            if (pend) begin
              act  <= shd;
              pend <= 1'b0;
            end
          end else begin
            lvl  <= 1'b0;
            ce_r <= 1'b0;
          end
        end else begin
          cnt  <= cnt + ONE;
          ce_r <= 1'b0;
        end

        // Acceptance only happens with nothing pending, so it never collides with an apply.
        if (accept) begin
          shd  <= fld;
          pend <= 1'b1;
        end
      end
    end

    assign div_clk[i] = lvl;
    assign ce[i]      = ce_r;
    assign pending[i] = pend;
  end

endmodule
